// File: rtl/hdmi_video_pkg.sv
// hdmi_video_pkg
//   Shared constants and types for the HDMI raster timing front end:
//   default 720p60 timing, counter/pixel widths, sync polarity constants,
//   the {R,G,B} pixel struct, the pipeline flag bundle and the colour-bar
//   lookup used by the optional test pattern (PATTERN_GEN_EN).
package hdmi_video_pkg;

    localparam int CNT_W = 12;
    localparam int PIX_W = 24;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;
    localparam int DEF_RD_LAT   = 2;

    localparam logic POL_HIGH = 1'b1;
    localparam logic POL_LOW  = 1'b0;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } pixel_t;

    // Flags travel active-high; sync polarity is applied only at the output.
    typedef struct packed {
        logic first;
        logic vs;
        logic hs;
        logic act;
    } flags_t;

    localparam int FLAGS_W = $bits(flags_t);

    // Bars run white, yellow, cyan, green, magenta, red, blue, black:
    // bit 2 of the index drops green, bit 1 drops red, bit 0 drops blue.
    function automatic pixel_t bar_color(input logic [2:0] bar);
        pixel_t c;
        c.red   = {8{~bar[1]}};
        c.green = {8{~bar[2]}};
        c.blue  = {8{~bar[0]}};
        return c;
    endfunction

endpackage

// File: rtl/hdmi_sig_delay.sv
// hdmi_sig_delay
//   Fixed-depth shift register that carries a flag bundle alongside the
//   pixel-source read latency. Reset flushes every stage to zero (idle).
// Ports
//   clk   in   clock
//   rst   in   async reset, active high
//   din   in   WIDTH  bundle entering the pipeline
//   dout  out  WIDTH  bundle delayed by DEPTH clocks
module hdmi_sig_delay
    import hdmi_video_pkg::*;
#(
    parameter int DEPTH = DEF_RD_LAT,
    parameter int WIDTH = FLAGS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing
//   Raster timing generator and pixel-fetch front end feeding the three TMDS
//   encoders. Walks h/v counters, requests pixels, and realigns the returned
//   data with de/hsync/vsync. Latency pix_req -> de is RD_LAT+1 clocks.
//   Optional colour-bar generator when the macro PATTERN_GEN_EN is defined
//   (adds the pattern_sel input).
// Ports
//   clkin        in   pixel clock
//   rstin        in   async reset, active high
//   enable       in   1 = run raster, 0 = hold idle at (0,0)
//   pix_req      out  pixel fetch strobe (combinational)
//   pix_x/pix_y  out  12  requested column/line (0 outside active area)
//   pix_data     in   24  {R,G,B}, valid RD_LAT clocks after pix_req
//   pix_valid    in   qualifies pix_data
//   pattern_sel  in   (PATTERN_GEN_EN only) 1 = colour bars
//   de           out  data enable
//   hsync/vsync  out  sync to blue encoder c0/c1
//   red/green/blue out 8 each, encoder din
//   frame_start  out  pulse with pixel (0,0) at the outputs
//   underflow    out  sticky: active pixel arrived with pix_valid=0
module hdmi_video_timing
    import hdmi_video_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = POL_HIGH,
    parameter logic VS_POL   = POL_HIGH,
    parameter int   RD_LAT   = DEF_RD_LAT
) (
    input  logic             clkin,
    input  logic             rstin,
    input  logic             enable,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
`ifdef PATTERN_GEN_EN
    input  logic             pattern_sel,
`endif
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             frame_start,
    output logic             underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

    generate
        if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_total_check
            $error("hdmi_video_timing: H_TOTAL/V_TOTAL exceed counter range");
        end
        if (RD_LAT < 1) begin : g_lat_check
            $error("hdmi_video_timing: RD_LAT must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST_C) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    logic act0;
    logic hs0;
    logic vs0;

    assign act0 = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hs0  = (h_cnt >= H_SS_C) && (h_cnt < H_SE_C);
    assign vs0  = (v_cnt >= V_SS_C) && (v_cnt < V_SE_C);

    assign pix_req = act0 & enable;
    assign pix_x   = act0 ? h_cnt : '0;
    assign pix_y   = act0 ? v_cnt : '0;

    // Gating with enable makes the pipeline drain with idle values.
    flags_t flags0;
    flags_t flags_d;

    always_comb begin
        flags0       = '0;
        flags0.act   = act0 & enable;
        flags0.hs    = hs0 & enable;
        flags0.vs    = vs0 & enable;
        flags0.first = enable && (h_cnt == '0) && (v_cnt == '0);
    end

    hdmi_sig_delay #(
        .DEPTH (RD_LAT),
        .WIDTH (FLAGS_W)
    ) u_flag_dly (
        .clk  (clkin),
        .rst  (rstin),
        .din  (flags0),
        .dout (flags_d)
    );

`ifdef PATTERN_GEN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    function automatic logic [2:0] bar_of(input logic [CNT_W-1:0] x);
        logic [2:0] b;
        b = '0;
        for (int i = 1; i < 8; i++) begin
            if (x >= CNT_W'(i * BAR_W)) b = 3'(i);
        end
        return b;
    endfunction

    logic [2:0] bar0;
    logic [2:0] bar_d;

    assign bar0 = bar_of(h_cnt);

    hdmi_sig_delay #(
        .DEPTH (RD_LAT),
        .WIDTH (3)
    ) u_bar_dly (
        .clk  (clkin),
        .rst  (rstin),
        .din  (bar0),
        .dout (bar_d)
    );
`endif

    pixel_t rgb_next;
    logic   uf_hit;

    always_comb begin
        rgb_next = '0;
        uf_hit   = 1'b0;
        if (flags_d.act) begin
`ifdef PATTERN_GEN_EN
            if (pattern_sel) rgb_next = bar_color(bar_d);
            else
`endif
            if (pix_valid) rgb_next = pix_data;
            else           uf_hit   = 1'b1;
        end
    end

    pixel_t rgb_q;

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            rgb_q       <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            de          <= flags_d.act;
            hsync       <= flags_d.hs ? HS_POL : ~HS_POL;
            vsync       <= flags_d.vs ? VS_POL : ~VS_POL;
            rgb_q       <= rgb_next;
            frame_start <= flags_d.first;
            if (!enable)     underflow <= 1'b0;
            else if (uf_hit) underflow <= 1'b1;
        end
    end

    assign red   = rgb_q.red;
    assign green = rgb_q.green;
    assign blue  = rgb_q.blue;

endmodule
